// File: rtl/axis_sample_pacer.sv
// AXI-Stream sample pacer: buffers producer samples in a FIFO and emits one beat per sample tick.
// Optional build macro AXIS_PACER_HOLD_LAST_EN re-issues the last sample on an underrun tick.
module axis_sample_pacer #(
    parameter int DATA_W = 32,
    parameter int CLK_HZ = 50_000_000,
    parameter int FS_HZ  = 500,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [DATA_W-1:0]        m_axis_tdata,
    input  logic                     clear_flags,
    output logic                     overflow,
    output logic                     underrun,
    output logic                     missed
);

    localparam int DIV   = CLK_HZ / FS_HZ;
    localparam int CNT_W = $clog2(DIV);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] LVL_EMPTY = LVL_W'(0);

    logic [CNT_W-1:0]  div_cnt_r;
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  level_r;
    logic [LVL_W-1:0]  level_nxt_s;
    logic              full_r;
    logic              tvalid_r;
    logic              tvalid_nxt_s;
    logic [DATA_W-1:0] tdata_r;
    logic [DATA_W-1:0] tdata_nxt_s;
    logic              overflow_r;
    logic              underrun_r;
    logic              missed_r;
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic tick_s;
    logic busy_s;
    logic xfer_s;
    logic push_s;
    logic pop_s;
    logic overflow_set_s;
    logic underrun_set_s;
    logic missed_set_s;
    logic reissue_s;

    assign tick_s = enable && (div_cnt_r == CNT_MAX);
    // A beat still waiting for the sink blocks the tick entirely.
    assign busy_s = tvalid_r && !m_axis_tready;
    assign xfer_s = tvalid_r && m_axis_tready;

    // Full comes from the registered level, so a same-cycle pop never frees room for a push.
    assign push_s         = wr_en && !full_r;
    assign overflow_set_s = wr_en && full_r;
    assign pop_s          = tick_s && !busy_s && (level_r != LVL_EMPTY);
    assign underrun_set_s = tick_s && !busy_s && (level_r == LVL_EMPTY);
    assign missed_set_s   = tick_s && busy_s;

`ifdef AXIS_PACER_HOLD_LAST_EN
    assign reissue_s = underrun_set_s;
`else
    assign reissue_s = 1'b0;
`endif

    // Next FIFO occupancy from push/pop pair.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_nxt_s = level_r + LVL_W'(1);
            2'b01:   level_nxt_s = level_r - LVL_W'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Next output beat; tdata is held whenever no new sample is popped.
    always_comb begin
        tvalid_nxt_s = tvalid_r;
        tdata_nxt_s  = tdata_r;
        if (pop_s) begin
            tvalid_nxt_s = 1'b1;
            tdata_nxt_s  = mem_r[rd_ptr_r];
        end else if (reissue_s) begin
            tvalid_nxt_s = 1'b1;
            tdata_nxt_s  = tdata_r;
        end else if (xfer_s) begin
            tvalid_nxt_s = 1'b0;
            tdata_nxt_s  = tdata_r;
        end else begin
            tvalid_nxt_s = tvalid_r;
            tdata_nxt_s  = tdata_r;
        end
    end

    // Sample-rate divider, held at zero while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= {CNT_W{1'b0}};
        end else if (!enable) begin
            div_cnt_r <= {CNT_W{1'b0}};
        end else if (div_cnt_r == CNT_MAX) begin
            div_cnt_r <= {CNT_W{1'b0}};
        end else begin
            div_cnt_r <= div_cnt_r + CNT_W'(1);
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
            full_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            level_r <= level_nxt_s;
            full_r  <= (level_nxt_s == LVL_FULL);
        end
    end

    // AXI-Stream output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvalid_r <= 1'b0;
            tdata_r  <= {DATA_W{1'b0}};
        end else begin
            tvalid_r <= tvalid_nxt_s;
            tdata_r  <= tdata_nxt_s;
        end
    end

    // Sticky flags; a set in the same cycle as clear_flags wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_r <= 1'b0;
            underrun_r <= 1'b0;
            missed_r   <= 1'b0;
        end else begin
            overflow_r <= overflow_set_s | (overflow_r & ~clear_flags);
            underrun_r <= underrun_set_s | (underrun_r & ~clear_flags);
            missed_r   <= missed_set_s   | (missed_r   & ~clear_flags);
        end
    end

    assign full          = full_r;
    assign level         = level_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tdata  = tdata_r;
    assign overflow      = overflow_r;
    assign underrun      = underrun_r;
    assign missed        = missed_r;

endmodule
